// File: rtl/riscv_pkg.sv
// Shared front-end constants and the fetch FSM encoding.
package riscv_pkg;

    localparam int              DEFAULT_ADDR_WIDTH    = 32;
    localparam logic [31:0]     DEFAULT_RESET_VECTOR  = 32'h0000_0000;
    localparam int              DEFAULT_CACHE_LATENCY = 3;
    localparam int              INSTR_BYTES           = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_tag_pipe.sv
// Shadow shift register that carries {valid, pc} alongside the instruction cache pipeline.
module fetch_tag_pipe #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_pc,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_pc
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] pc_q [DEPTH];

    // A flush only kills the valid bits; the stale pc fields are harmless once invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (!hold) begin
            valid_q[0] <= in_valid;
            pc_q[0]    <= in_pc;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                pc_q[i]    <= pc_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_pc    = pc_q[DEPTH-1];

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter generator: issues fetch addresses, tracks them through the cache
// latency and hands the matching PC / PC+4 to decode, with redirect, stall and halt.
module pc_fetch_unit
    import riscv_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR  = ADDR_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int                    CACHE_LATENCY = DEFAULT_CACHE_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  cache_ready,
    output logic [ADDR_WIDTH-1:0] pc_to_cache,
    output logic                  pc_valid,
    output logic [ADDR_WIDTH-1:0] pc_to_decode,
    output logic [ADDR_WIDTH-1:0] pc_plus4_to_decode,
    output logic                  instr_valid,
    output logic                  misaligned_exc
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INSTR_BYTES);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  fire;
    logic                  target_aligned;
    logic                  last_valid;
    logic [ADDR_WIDTH-1:0] last_pc;

    assign pc_valid       = (state == RUN);
    assign pc_to_cache    = pc;
    assign target_aligned = is_word_aligned(branch_target[1:0]);
    assign fire           = pc_valid & cache_ready & ~stall & ~branch_taken;

    // A redirect wins over stall and cache backpressure; BOOT always burns exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= BOOT;
            pc             <= RESET_VECTOR;
            misaligned_exc <= 1'b0;
        end else begin
            misaligned_exc <= branch_taken & ~target_aligned;
            if (branch_taken) begin
                if (target_aligned) begin
                    pc    <= branch_target;
                    state <= RUN;
                end else begin
                    state <= HALT;
                end
            end else begin
                if (fire) begin
                    pc <= pc + STEP;
                end
                if (state == BOOT) begin
                    state <= RUN;
                end
            end
        end
    end

    fetch_tag_pipe #(
        .DEPTH (CACHE_LATENCY),
        .WIDTH (ADDR_WIDTH)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (stall),
        .flush     (branch_taken),
        .in_valid  (fire),
        .in_pc     (pc),
        .out_valid (last_valid),
        .out_pc    (last_pc)
    );

    // The link value reads zero for bubbles so the decode side sees a clean 0 out of reset.
    assign instr_valid        = last_valid;
    assign pc_to_decode       = last_pc;
    assign pc_plus4_to_decode = last_valid ? (last_pc + STEP) : '0;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and random checks of pc_fetch_unit against a queue-based fetch history model.
module tb_pc_fetch_unit;

    localparam int LAT = 3;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        cache_ready;
    logic [31:0] pc_to_cache;
    logic        pc_valid;
    logic [31:0] pc_to_decode;
    logic [31:0] pc_plus4_to_decode;
    logic        instr_valid;
    logic        misaligned_exc;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 = booting, 1 = running, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_exc;
    ent_t        hist[$];

    pc_fetch_unit dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stall              (stall),
        .branch_taken       (branch_taken),
        .branch_target      (branch_target),
        .cache_ready        (cache_ready),
        .pc_to_cache        (pc_to_cache),
        .pc_valid           (pc_valid),
        .pc_to_decode       (pc_to_decode),
        .pc_plus4_to_decode (pc_plus4_to_decode),
        .instr_valid        (instr_valid),
        .misaligned_exc     (misaligned_exc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 32'h0;
        m_exc  = 1'b0;
        hist.delete();
    endtask

    // Each non-stalled edge records what was fetched; decode shows the record LAT edges old.
    task automatic model_edge();
        logic fired;
        if (!rst_n) return;
        fired = (m_mode == 1) && cache_ready && !stall && !branch_taken;
        if (branch_taken) begin
            foreach (hist[i]) hist[i].v = 1'b0;
            m_exc = (branch_target % 4) != 0;
            if (!m_exc) begin
                m_pc   = branch_target;
                m_mode = 1;
            end else begin
                m_mode = 2;
            end
        end else begin
            m_exc = 1'b0;
            if (!stall) begin
                hist.push_back('{v: fired, pc: m_pc});
                if (hist.size() > LAT) void'(hist.pop_front());
            end
            if (fired) m_pc = m_pc + 32'd4;
            if (m_mode == 0) m_mode = 1;
        end
    endtask

    function automatic ent_t decode_entry();
        if (hist.size() >= LAT) return hist[hist.size() - LAT];
        return '0;
    endfunction

    task automatic check_output(input bit at_reset);
        ent_t e;
        e = decode_entry();
        chk("pc_valid", {31'b0, pc_valid}, {31'b0, m_mode == 1});
        chk("pc_to_cache", pc_to_cache, m_pc);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, e.v});
        chk("misaligned_exc", {31'b0, misaligned_exc}, {31'b0, m_exc});
        if (e.v) begin
            chk("pc_to_decode", pc_to_decode, e.pc);
            chk("pc_plus4", pc_plus4_to_decode, e.pc + 32'd4);
        end
        if (at_reset) begin
            chk("pc_to_decode_rst", pc_to_decode, 32'h0);
            chk("pc_plus4_rst", pc_plus4_to_decode, 32'h0);
        end
    endtask

    task automatic apply_stimulus(input logic st, input logic bt, input logic [31:0] tgt,
                                  input logic rdy);
        stall         = st;
        branch_taken  = bt;
        branch_target = tgt;
        cache_ready   = rdy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_output(1'b0);
    endtask

    task automatic mid_cycle_reset();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_output(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        check_output(1'b1);
    endtask

    initial begin
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        cache_ready   = 1'b1;
        model_reset();
        #2;
        check_output(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        check_output(1'b1);

        $display("[TB] T1 reset release and first fetches");
        apply_stimulus(0, 0, 0, 1);
        chk("t1_pc0", pc_to_cache, 32'h0);
        apply_stimulus(0, 0, 0, 1);
        chk("t1_pc4", pc_to_cache, 32'h4);
        apply_stimulus(0, 0, 0, 1);
        chk("t1_pc8", pc_to_cache, 32'h8);
        chk("t1_iv_low", {31'b0, instr_valid}, 32'h0);
        apply_stimulus(0, 0, 0, 1);
        chk("t1_iv_high", {31'b0, instr_valid}, 32'h1);
        chk("t1_dec", pc_to_decode, 32'h0);
        chk("t1_plus4", pc_plus4_to_decode, 32'h4);

        $display("[TB] T2 stall freeze");
        apply_stimulus(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 0, 0, 1);
            chk("t2_hold_pc", pc_to_cache, 32'h10);
        end
        apply_stimulus(0, 0, 0, 1);
        chk("t2_resume", pc_to_cache, 32'h14);
        apply_stimulus(0, 0, 0, 1);

        $display("[TB] T3 redirect with stall");
        apply_stimulus(1, 1, 32'h100, 1);
        chk("t3_pc", pc_to_cache, 32'h100);
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(0, 0, 0, 1);
            chk("t3_flushed", {31'b0, instr_valid}, 32'h0);
        end
        apply_stimulus(0, 0, 0, 1);
        chk("t3_arrive", pc_to_decode, 32'h100);

        $display("[TB] T4 misaligned halt");
        apply_stimulus(0, 1, 32'h102, 1);
        chk("t4_exc", {31'b0, misaligned_exc}, 32'h1);
        chk("t4_halt", {31'b0, pc_valid}, 32'h0);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, 1);
        apply_stimulus(0, 1, 32'h200, 1);
        chk("t4_resume", pc_to_cache, 32'h200);
        apply_stimulus(0, 0, 0, 1);

        $display("[TB] T5 wrap-around");
        apply_stimulus(0, 1, 32'hFFFF_FFF8, 1);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, 1);
        chk("t5_dec", pc_to_decode, 32'hFFFF_FFFC);
        chk("t5_plus4", pc_plus4_to_decode, 32'h0);

        $display("[TB] T6 cache backpressure and mid-run reset");
        for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 0, i[0] == 1'b0);
        mid_cycle_reset();
        apply_stimulus(0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 1);
        chk("t6_restart", pc_to_cache, 32'h4);

        $display("[TB] random phase");
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 99) == 0) begin
                mid_cycle_reset();
            end else begin
                apply_stimulus($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, tgt,
                               $urandom_range(0, 3) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
